// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU. Single-cycle ADD/SUB/MUL/logic ops.
// DIV/MOD run on an iterative restoring divider that takes WIDTH cycles.
// Build option: define ALU_SEQ_DIV_EN to include the divider. When it is
// undefined, DIV/MOD complete at once with result 0 and out_dbz set.
// Each result is held in an output register until the sink consumes it.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_dbz,
  output logic             busy
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic               accept_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     diff_c;
  logic [PROD_W-1:0]  prod_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_carry_c;
  logic               alu_ovf_c;
  logic               alu_dbz_c;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mod_q, mod_d;
  logic               start_div_c;
  logic [WIDTH:0]     rem_sh_c;
  logic               ge_c;
  logic [WIDTH-1:0]   rem_nx_c;
  logic [WIDTH-1:0]   quo_nx_c;
`endif

  // Handshake: accept from IDLE, or from HOLD when the held result drains now
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept_c  = in_valid && in_ready;

  assign out_valid  = (state_q == S_HOLD);
  assign out_result = res_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_dbz    = dbz_q;

`ifdef ALU_SEQ_DIV_EN
  assign busy = (state_q == S_BUSY);
`else
  assign busy = 1'b0;
`endif

  // Single-cycle result and flags for the operation presented at the input
  always_comb begin
    sum_c       = {1'b0, in_a} + {1'b0, in_b};
    diff_c      = {1'b0, in_a} - {1'b0, in_b};
    prod_c      = PROD_W'(in_a) * PROD_W'(in_b);
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    alu_dbz_c   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    start_div_c = 1'b0;
`endif
    case (in_op)
      OP_ADD: begin
        alu_res_c   = sum_c[WIDTH-1:0];
        alu_carry_c = sum_c[WIDTH];
        alu_ovf_c   = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                      (sum_c[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c   = diff_c[WIDTH-1:0];
        alu_carry_c = diff_c[WIDTH];
        alu_ovf_c   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                      (diff_c[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_MUL: begin
        alu_res_c   = prod_c[WIDTH-1:0];
        alu_carry_c = |prod_c[PROD_W-1:WIDTH];
      end
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        if (in_b == '0) begin
          alu_res_c = '1;
          alu_dbz_c = 1'b1;
        end else begin
          start_div_c = 1'b1;
        end
`else
        alu_dbz_c = 1'b1;
`endif
      end
      OP_MOD: begin
`ifdef ALU_SEQ_DIV_EN
        if (in_b == '0) begin
          alu_res_c = in_a;
          alu_dbz_c = 1'b1;
        end else begin
          start_div_c = 1'b1;
        end
`else
        alu_dbz_c = 1'b1;
`endif
      end
      OP_AND:  alu_res_c = in_a & in_b;
      OP_OR:   alu_res_c = in_a | in_b;
      OP_XOR:  alu_res_c = in_a ^ in_b;
      default: alu_res_c = '0;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  // One restoring step: shift {rem, quo} left, trial-subtract the divisor
  always_comb begin
    rem_sh_c = {rem_q, quo_q[WIDTH-1]};
    ge_c     = (rem_sh_c >= {1'b0, dvs_q});
    rem_nx_c = ge_c ? WIDTH'(rem_sh_c - {1'b0, dvs_q}) : rem_sh_c[WIDTH-1:0];
    quo_nx_c = {quo_q[WIDTH-2:0], ge_c};
  end
`endif

  // Next-state and next-value logic for control and result registers
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
`ifdef ALU_SEQ_DIV_EN
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
`endif
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept_c) begin
`ifdef ALU_SEQ_DIV_EN
          if (start_div_c) begin
            state_d = S_BUSY;
            quo_d   = in_a;
            dvs_d   = in_b;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            mod_d   = (in_op == OP_MOD);
          end else begin
            state_d = S_HOLD;
            res_d   = alu_res_c;
            carry_d = alu_carry_c;
            zero_d  = (alu_res_c == '0);
            ovf_d   = alu_ovf_c;
            dbz_d   = alu_dbz_c;
          end
`else
          state_d = S_HOLD;
          res_d   = alu_res_c;
          carry_d = alu_carry_c;
          zero_d  = (alu_res_c == '0);
          ovf_d   = alu_ovf_c;
          dbz_d   = alu_dbz_c;
`endif
        end else if ((state_q == S_HOLD) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
`ifdef ALU_SEQ_DIV_EN
        quo_d = quo_nx_c;
        rem_d = rem_nx_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_HOLD;
          res_d   = mod_q ? rem_nx_c : quo_nx_c;
          carry_d = 1'b0;
          zero_d  = mod_q ? (rem_nx_c == '0) : (quo_nx_c == '0);
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight division
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef ALU_SEQ_DIV_EN
  // Divider working registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quo_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      mod_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      mod_q <= mod_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random stimulus for alu_seq, checked against a
// transaction-level model (plain arithmetic, result hold and divider latency).
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_zero;
  logic         out_ovf;
  logic         out_dbz;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Model state: held result, validity, and remaining divider cycles
  bit     m_valid;
  int     m_busy;
  longint m_res;
  bit     m_c, m_z, m_o, m_d;
  longint p_res;
  bit     p_c, p_z, p_o, p_d;

  alu_seq #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_dbz    (out_dbz),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit div_is_multicycle(input logic [2:0] op, input longint b);
`ifdef ALU_SEQ_DIV_EN
    return ((op == 3'd3) || (op == 3'd4)) && (b != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference arithmetic from the operation definitions
  task automatic model_op(input logic [2:0] op, input longint a, input longint b,
                          output longint r, output bit c, output bit z,
                          output bit o, output bit d);
    longint m, half, sa, sb, ss;
    m    = longint'(1) << W;
    half = longint'(1) << (W - 1);
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    r = 0; c = 0; o = 0; d = 0;
    case (op)
      3'd0: begin
        r  = (a + b) % m;
        c  = (a + b) >= m;
        ss = sa + sb;
        o  = (ss > half - 1) || (ss < -half);
      end
      3'd1: begin
        r  = (a - b + m) % m;
        c  = a < b;
        ss = sa - sb;
        o  = (ss > half - 1) || (ss < -half);
      end
      3'd2: begin
        r = (a * b) % m;
        c = (a * b) >= m;
      end
      3'd3: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == 0) begin r = m - 1; d = 1; end
        else r = a / b;
`else
        d = 1;
`endif
      end
      3'd4: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == 0) begin r = a; d = 1; end
        else r = a % b;
`else
        d = 1;
`endif
      end
      3'd5: r = a & b;
      3'd6: r = a | b;
      default: r = a ^ b;
    endcase
    z = (r == 0);
  endtask

  task automatic model_reset();
    m_valid = 0; m_busy = 0;
    m_res = 0; m_c = 0; m_z = 0; m_o = 0; m_d = 0;
  endtask

  task automatic check_outputs();
    check("out_valid",  out_valid,  m_valid);
    check("busy",       busy,       m_busy > 0);
    check("out_result", out_result, m_res);
    check("out_carry",  out_carry,  m_c);
    check("out_zero",   out_zero,   m_z);
    check("out_ovf",    out_ovf,    m_o);
    check("out_dbz",    out_dbz,    m_d);
  endtask

  // One clock cycle: drive at negedge, predict the edge, check after it
  task automatic cycle(input bit v, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit ordy);
    bit exp_rdy, acc;
    longint r;
    bit c, z, o, d;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    exp_rdy = (m_busy == 0) && (!m_valid || ordy);
    check("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    model_op(op, longint'(a), longint'(b), r, c, z, o, d);
    @(posedge clock);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1;
        m_res = p_res; m_c = p_c; m_z = p_z; m_o = p_o; m_d = p_d;
      end
    end else begin
      if (m_valid && ordy) m_valid = 0;
      if (acc) begin
        if (div_is_multicycle(op, longint'(b))) begin
          m_busy = W;
          p_res = r; p_c = c; p_z = z; p_o = o; p_d = d;
        end else begin
          m_valid = 1;
          m_res = r; m_c = c; m_z = z; m_o = o; m_d = d;
        end
      end
    end
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  function automatic logic [W-1:0] pick_operand(input int zero_weight);
    int sel;
    sel = $urandom_range(0, 15);
    if (sel < zero_weight) return '0;
    if (sel == 14) return '1;
    if (sel == 15) return W'(1) << (W - 1);
    return W'($urandom);
  endfunction

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    check("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;

    // ADD 200+100
    cycle(1, 3'd0, 8'd200, 8'd100, 1);
    check("add_res",   out_result, 8'h2C);
    check("add_carry", out_carry, 1'b1);
    check("add_ovf",   out_ovf, 1'b0);
    check("add_zero",  out_zero, 1'b0);

    // SUB then MUL accepted on consecutive cycles
    cycle(1, 3'd1, 8'h80, 8'h01, 1);
    check("sub_res",   out_result, 8'h7F);
    check("sub_carry", out_carry, 1'b0);
    check("sub_ovf",   out_ovf, 1'b1);
    cycle(1, 3'd2, 8'd16, 8'd20, 1);
    check("mul_res",   out_result, 8'h40);
    check("mul_carry", out_carry, 1'b1);

    // DIV and MOD 200/7, in_valid kept high during BUSY
`ifdef ALU_SEQ_DIV_EN
    cycle(1, 3'd3, 8'd200, 8'd7, 1);
    for (int i = 0; i < int'(W) - 1; i++) begin
      check("div_busy", busy, 1'b1);
      cycle(1, 3'd0, 8'd9, 8'd9, 1);
    end
    check("div_busy_last", busy, 1'b1);
    check("div_not_valid", out_valid, 1'b0);
    cycle(1, 3'd0, 8'd9, 8'd9, 1);
    check("div_valid", out_valid, 1'b1);
    check("div_res",   out_result, 8'd28);
    cycle(1, 3'd4, 8'd200, 8'd7, 1);
    for (int i = 0; i < int'(W); i++) cycle(1, 3'd6, 8'd1, 8'd2, 1);
    check("mod_valid", out_valid, 1'b1);
    check("mod_res",   out_result, 8'd4);
`else
    cycle(1, 3'd3, 8'd200, 8'd7, 1);
    check("div_res",  out_result, 8'd0);
    check("div_dbz",  out_dbz, 1'b1);
    check("div_zero", out_zero, 1'b1);
    check("div_busy", busy, 1'b0);
`endif

    // Divide by zero
    cycle(1, 3'd3, 8'h55, 8'h00, 1);
`ifdef ALU_SEQ_DIV_EN
    check("dbz_div_res", out_result, 8'hFF);
`else
    check("dbz_div_res", out_result, 8'h00);
`endif
    check("dbz_div_flag", out_dbz, 1'b1);
    cycle(1, 3'd4, 8'h55, 8'h00, 1);
`ifdef ALU_SEQ_DIV_EN
    check("dbz_mod_res", out_result, 8'h55);
`else
    check("dbz_mod_res", out_result, 8'h00);
`endif
    check("dbz_mod_flag", out_dbz, 1'b1);

    // Backpressure with a second op waiting on in_valid
    cycle(0, 3'd0, 8'd0, 8'd0, 1);
    cycle(1, 3'd0, 8'd1, 8'd1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 3'd0, 8'd2, 8'd2, 0);
      check("bp_hold_res", out_result, 8'd2);
      check("bp_hold_rdy", in_ready, 1'b0);
    end
    cycle(1, 3'd0, 8'd2, 8'd2, 1);
    check("bp_next_res", out_result, 8'd4);
    check("bp_next_vld", out_valid, 1'b1);

    // Reset during a division
    cycle(0, 3'd0, 8'd0, 8'd0, 1);
    cycle(1, 3'd3, 8'd255, 8'd3, 1);
    for (int i = 0; i < 3; i++) cycle(0, 3'd0, 8'd0, 8'd0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_mid_rdy", in_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < int'(W) + 4; i++) begin
      cycle(0, 3'd0, 8'd0, 8'd0, 1);
      check("rst_no_result", out_valid, 1'b0);
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
            pick_operand(1), pick_operand(3), $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU. It is the handshaked, multi-cycle successor to the team's 8-bit registered ALU. It accepts one operation at a time over a valid/ready input channel and computes ADD/SUB/MUL in one cycle. DIV/MOD use an iterative restoring divider over WIDTH cycles. Each result and its flags are held in an output register until a valid/ready output channel consumes them. It sits between an operand-issuing controller and a result sink that may apply backpressure.

## Interface
- WIDTH, 8, operand and result width in bits; WIDTH >= 2.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation this cycle.
- in_op  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR.
- in_a, in_b  input  WIDTH  operands, unsigned.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  sink accepts the result.
- out_result  output  WIDTH  result.
- out_carry  output  1  carry/borrow/multiply-overflow flag.
- out_zero  output  1  out_result == 0.
- out_ovf  output  1  signed overflow flag for ADD/SUB.
- out_dbz  output  1  divide-by-zero flag.
- busy  output  1  divider iterating.

## Operation
- States: IDLE, BUSY, HOLD.
- in_ready = (state == IDLE) || (state == HOLD && out_ready). It is combinational from state and out_ready, and never depends on in_valid.
- Accept = in_valid && in_ready. On accept:
  - ADD, SUB, MUL, AND, OR, XOR, and DIV/MOD with in_b == 0: the result and flags are registered, and the state becomes HOLD.
  - DIV/MOD with in_b != 0: the operands are latched, the remainder is cleared, the counter is loaded with WIDTH, and the state becomes BUSY.
- BUSY runs one restoring step per cycle: shift {rem, quotient} left by 1, trial-subtract the divisor, and set the quotient bit if the subtraction does not underflow.
  - On the step where counter == 1, the state becomes HOLD and out_result = quotient (DIV) or remainder (MOD).
  - in_valid is ignored in BUSY.
- HOLD: outputs are stable. When out_ready is high and no accept occurs, the state becomes IDLE. When an accept occurs in the same cycle, the next op is processed as from IDLE.
- Arithmetic and flags (results truncated to WIDTH):
  - ADD: out_carry = bit WIDTH of the (WIDTH+1)-bit sum. out_ovf = operand sign bits equal and result sign bit different.
  - SUB: out_carry = borrow (in_a < in_b). out_ovf = operand sign bits differ and result sign bit differs from in_a's sign bit.
  - MUL: out_result = low WIDTH bits of the 2·WIDTH product. out_carry = high half nonzero. out_ovf = 0.
  - DIV/MOD/logic: out_carry = 0, out_ovf = 0.
  - out_zero is computed from the final out_result for every op.
  - Divide by zero: DIV returns all ones and MOD returns in_a. Both set out_dbz = 1. out_dbz = 0 for every other case.
- Reset (asynchronous, immediate): state IDLE, out_valid 0, busy 0, out_result 0, all flags 0, counter 0. An in-flight division is discarded and produces no result.

## Timing
- Single-cycle ops and divide-by-zero: accepted at edge k, out_valid high after edge k. Latency 1.
- DIV/MOD: accepted at edge k; busy is high after edges k..k+WIDTH-1; out_valid is high after edge k+WIDTH. Latency WIDTH.
- Throughput:
  - Single-cycle ops: 1 op/cycle with out_ready held high.
  - DIV/MOD: one op per WIDTH+1 cycles minimum.
- out_valid falls on the edge of consumption unless a new single-cycle result replaces it on that same edge.
- out_* registers change only on accept/completion edges or reset.

## Configuration
- ALU_SEQ_DIV_EN defined: the divider datapath and the BUSY state are built as described.
- ALU_SEQ_DIV_EN undefined: no divider logic and BUSY is never entered.
  - DIV/MOD complete in one cycle with out_result = 0 and out_dbz = 1 (reused as an unsupported-op indication). All other flags except out_zero are 0; out_zero = 1 since the result is 0.
  - busy is tied 0.
  - All other ops are unchanged.

## Test plan
- ADD 200+100 (WIDTH 8), out_ready high: after 1 cycle, result 0x2C, carry 1, ovf 0, zero 0.
- SUB 0x80-0x01, then MUL 16×20: results 0x7F with carry 0, ovf 1; then 0x40 with carry 1. The two ops are accepted on consecutive cycles.
- DIV 200/7, then MOD 200/7: result 28, then result 4. For each:
  - out_valid rises exactly 8 cycles after accept.
  - busy is high for 8 cycles.
  - in_ready is low throughout BUSY.
- DIV 0x55/0 and MOD 0x55/0: after 1 cycle, 0xFF with dbz 1, then 0x55 with dbz 1. With ALU_SEQ_DIV_EN undefined, DIV 200/7 returns 0 with dbz 1 after 1 cycle.
- Backpressure: ADD 1+1 accepted, out_ready low for 3 cycles, second op ADD 2+2 held on in_valid.
  - During the stall: out_result stays 2 and in_ready stays 0.
  - When out_ready rises, the second op is accepted on the same edge, and 4 appears the next cycle.
- Reset mid-division: DIV 255/3, reset_n pulled low in the 4th BUSY cycle. All outputs go to 0 immediately. After release the state is IDLE and in_ready is 1; no result ever appears.
